// File: rtl/led_pkg.sv
// ----------------------------------------------------------------------------
// led_pkg : shared types and constants for the LED sweep controller
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package led_pkg;

  localparam int LED_W = 16;

  typedef enum logic [1:0] {
    MODE_BOUNCE     = 2'd0,
    MODE_WRAP_LEFT  = 2'd1,
    MODE_WRAP_RIGHT = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN_L = 2'd1,
    ST_RUN_R = 2'd2,
    ST_DWELL = 2'd3
  } sweep_state_t;

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_BOUNCE:    return MODE_WRAP_LEFT;
      MODE_WRAP_LEFT: return MODE_WRAP_RIGHT;
      default:        return MODE_BOUNCE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/tick_gen.sv
// ----------------------------------------------------------------------------
// tick_gen : one-cycle tick every CLK_FREQ/RATE_HZ cycles while enabled
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tick_gen #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned RATE_HZ  = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tick
);

  localparam int unsigned c_TERM  = CLK_FREQ / RATE_HZ;
  localparam int unsigned c_CNT_W = (c_TERM > 1) ? $clog2(c_TERM) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_TERM - 1);

  logic [c_CNT_W-1:0] r_cnt;
  logic               w_at_last;

  assign w_at_last = (r_cnt == c_LAST);
  assign tick      = en && w_at_last;

  // Disabled means cleared, so every enable starts a full period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (!en || w_at_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/led_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// led_sweep_ctrl : single-LED sweep with bounce and wrap modes
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module led_sweep_ctrl
  import led_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 100_000_000,
  parameter int unsigned STEP_HZ     = 8,
  parameter int unsigned DWELL_STEPS = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_pls,
  input  logic             stop_pls,
  input  logic             mode_pls,
  output logic [1:0]       mode,
  output logic [3:0]       pos,
  output logic [LED_W-1:0] led,
  output logic             busy,
  output logic             end_hit
);

  localparam logic [3:0] c_POS_MAX  = 4'(LED_W - 1);
  localparam logic [3:0] c_DWELL_LAST = 4'(DWELL_STEPS - 1);

  sweep_state_t r_state, w_state_nxt;
  mode_t        r_mode,  w_mode_nxt;
  logic [3:0]   r_pos,   w_pos_nxt;
  logic [3:0]   r_dwell_cnt, w_dwell_nxt;
  logic         r_ret_r, w_ret_r_nxt;
  logic         r_end_hit, w_end_hit_nxt;
  logic         w_tick;
  logic         w_busy;

  assign w_busy = (r_state != ST_IDLE);

  tick_gen #(
    .CLK_FREQ (CLK_FREQ),
    .RATE_HZ  (STEP_HZ)
  ) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (w_busy),
    .tick    (w_tick)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_mode_nxt    = r_mode;
    w_pos_nxt     = r_pos;
    w_dwell_nxt   = r_dwell_cnt;
    w_ret_r_nxt   = r_ret_r;
    w_end_hit_nxt = 1'b0;

    if (r_state == ST_IDLE && mode_pls) begin
      w_mode_nxt = next_mode(r_mode);
    end

    if (stop_pls) begin
      w_state_nxt = ST_IDLE;
      w_dwell_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Direction follows the mode in force before any same-cycle mode_pls.
          if (start_pls) begin
            w_state_nxt = (r_mode == MODE_WRAP_RIGHT) ? ST_RUN_R : ST_RUN_L;
          end
        end
        ST_RUN_L: begin
          if (w_tick) begin
            if (r_pos != c_POS_MAX) begin
              w_pos_nxt = r_pos + 4'd1;
            end else if (r_mode == MODE_BOUNCE) begin
              w_state_nxt   = ST_DWELL;
              w_ret_r_nxt   = 1'b1;
              w_dwell_nxt   = '0;
              w_end_hit_nxt = 1'b1;
            end else begin
              w_pos_nxt = '0;
            end
          end
        end
        ST_RUN_R: begin
          if (w_tick) begin
            if (r_pos != 4'd0) begin
              w_pos_nxt = r_pos - 4'd1;
            end else if (r_mode == MODE_BOUNCE) begin
              w_state_nxt   = ST_DWELL;
              w_ret_r_nxt   = 1'b0;
              w_dwell_nxt   = '0;
              w_end_hit_nxt = 1'b1;
            end else begin
              w_pos_nxt = c_POS_MAX;
            end
          end
        end
        ST_DWELL: begin
          if (w_tick) begin
            if (r_dwell_cnt == c_DWELL_LAST) begin
              w_state_nxt = r_ret_r ? ST_RUN_R : ST_RUN_L;
              w_dwell_nxt = '0;
            end else begin
              w_dwell_nxt = r_dwell_cnt + 4'd1;
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_mode      <= MODE_BOUNCE;
      r_pos       <= '0;
      r_dwell_cnt <= '0;
      r_ret_r     <= 1'b0;
      r_end_hit   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mode      <= w_mode_nxt;
      r_pos       <= w_pos_nxt;
      r_dwell_cnt <= w_dwell_nxt;
      r_ret_r     <= w_ret_r_nxt;
      r_end_hit   <= w_end_hit_nxt;
    end
  end

  assign mode    = r_mode;
  assign pos     = r_pos;
  assign led     = {{(LED_W-1){1'b0}}, 1'b1} << r_pos;
  assign busy    = w_busy;
  assign end_hit = r_end_hit;

endmodule

`default_nettype wire

// File: tb/tb_led_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// tb_led_sweep_ctrl : directed and random checks of led_sweep_ctrl
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_led_sweep_ctrl;

  localparam int CLK_FREQ = 100;
  localparam int STEP_HZ  = 10;
  localparam int DWELL    = 2;
  localparam int TERM     = CLK_FREQ / STEP_HZ;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_pls = 1'b0;
  logic        stop_pls = 1'b0;
  logic        mode_pls = 1'b0;
  logic [1:0]  mode;
  logic [3:0]  pos;
  logic [15:0] led;
  logic        busy;
  logic        end_hit;

  int checks = 0;
  int failures = 0;

  // Reference model: abstract sweep position, direction and dwell budget.
  int m_pos, m_mode, m_div, m_dir, m_ret, m_dwell_left;
  bit m_busy, m_end;

  led_sweep_ctrl #(
    .CLK_FREQ    (CLK_FREQ),
    .STEP_HZ     (STEP_HZ),
    .DWELL_STEPS (DWELL)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start_pls (start_pls),
    .stop_pls  (stop_pls),
    .mode_pls  (mode_pls),
    .mode      (mode),
    .pos       (pos),
    .led       (led),
    .busy      (busy),
    .end_hit   (end_hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_mode = 0; m_div = 0; m_dir = 1; m_ret = 1;
    m_dwell_left = 0; m_busy = 0; m_end = 0;
  endtask

  task automatic model_edge(input bit s, input bit p, input bit m);
    bit tick;
    int np;
    int old_mode;
    tick     = m_busy && (m_div == TERM - 1);
    m_div    = m_busy ? (m_div + 1) % TERM : 0;
    old_mode = m_mode;
    m_end    = 0;
    if (!m_busy && m) m_mode = (m_mode + 1) % 3;
    if (p) begin
      m_busy = 0;
      m_dwell_left = 0;
    end else if (!m_busy) begin
      if (s) begin
        m_busy = 1;
        m_dir = (old_mode == 2) ? -1 : 1;
      end
    end else if (tick) begin
      if (m_dwell_left > 0) begin
        m_dwell_left--;
        if (m_dwell_left == 0) m_dir = m_ret;
      end else begin
        np = m_pos + m_dir;
        if (np >= 0 && np <= 15) m_pos = np;
        else if (m_mode == 0) begin
          m_dwell_left = DWELL;
          m_ret = -m_dir;
          m_end = 1;
        end else m_pos = (np + 16) % 16;
      end
    end
  endtask

  task automatic check_all();
    logic [15:0] one;
    one = 16'h0001;
    chk("led_onehot", 32'($onehot(led)), 32'd1);
    chk("led_decode", 32'(led), 32'(one << pos));
    chk("pos", 32'(pos), 32'(m_pos));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("mode", 32'(mode), 32'(m_mode));
    chk("end_hit", 32'(end_hit), 32'(m_end));
  endtask

  task automatic step(input bit s, input bit p, input bit m);
    start_pls = s; stop_pls = p; mode_pls = m;
    @(posedge clk);
    model_edge(s, p, m);
    @(negedge clk);
    start_pls = 0; stop_pls = 0; mode_pls = 0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (2) @(negedge clk);
    check_all();
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // Bounce sweep: 15 steps up, end pulse, two-tick dwell, back down.
    step(1, 0, 0);
    idle(10);  chk("b_first_step", 32'(pos), 32'd1);
    idle(140); chk("b_pos15", 32'(pos), 32'd15);
    idle(10);  chk("b_end_hit", 32'(end_hit), 32'd1);
    idle(1);   chk("b_end_once", 32'(end_hit), 32'd0);
    idle(19);  chk("b_dwell_hold", 32'(pos), 32'd15);
    idle(10);  chk("b_return", 32'(pos), 32'd14);
    step(0, 1, 0);

    // Wrap-right from position 0.
    do_reset();
    step(0, 0, 1);
    step(0, 0, 1);
    chk("wr_mode", 32'(mode), 32'd2);
    step(1, 0, 0);
    idle(10);  chk("wr_wrap", 32'(pos), 32'd15);
    idle(10);  chk("wr_next", 32'(pos), 32'd14);
    step(0, 1, 0);

    // Stop at 5, hold, resume.
    do_reset();
    step(1, 0, 0);
    idle(50);  chk("st_pos5", 32'(pos), 32'd5);
    step(0, 1, 0);
    chk("st_busy", 32'(busy), 32'd0);
    idle(100); chk("st_led", 32'(led), 32'h0020);
    step(1, 0, 0);
    idle(10);  chk("st_resume", 32'(pos), 32'd6);

    // Start+stop together, and mode_pls while busy.
    step(0, 1, 0);
    step(1, 1, 0);
    chk("ss_busy", 32'(busy), 32'd0);
    step(1, 0, 0);
    step(0, 0, 1);
    chk("mb_mode", 32'(mode), 32'd0);
    step(0, 1, 0);

    // Asynchronous reset in the middle of a dwell.
    do_reset();
    step(1, 0, 0);
    idle(165);
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("ar_pos", 32'(pos), 32'd0);
    chk("ar_led", 32'(led), 32'h0001);
    chk("ar_mode", 32'(mode), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Random pulses against the model.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 199) == 0),
           ($urandom_range(0, 29) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
